mas_alu_mc_top: RTL and testbench



---
 rtl/mas_alu_pkg.sv | 31 +++
 rtl/mas_alu_rr_arb.sv | 36 +++
 rtl/mas_alu_mc_top.sv | 164 ++++++++++++++++
 tb/tb_mas_alu_mc_top.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mas_alu_pkg.sv
// Shared types and defaults for the MAS ALU slice: command encoding, FSM states,
// default widths and the channel-ID width helper.
package mas_alu_pkg;

    localparam int MAS_ALU_BLEN = 32;
    localparam int MAS_ALU_NCH  = 4;

    // 4-bit command space; codes 9..15 are illegal
    typedef enum logic [3:0] {
        MAS_ALU_ADD = 4'h0,
        MAS_ALU_SUB = 4'h1,
        MAS_ALU_AND = 4'h2,
        MAS_ALU_OR  = 4'h3,
        MAS_ALU_XOR = 4'h4,
        MAS_ALU_SLL = 4'h5,
        MAS_ALU_SRL = 4'h6,
        MAS_ALU_SRA = 4'h7,
        MAS_ALU_MUL = 4'h8
    } type_mas_alu_cmd;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } type_mas_alu_state;

    function automatic int mas_alu_idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mas_alu_rr_arb.sv
// Round-robin arbiter: grants the first requesting channel at or after ptr,
// wrapping NCH-1 -> 0.
module mas_alu_rr_arb
    import mas_alu_pkg::*;
#(
    parameter int  NCH = MAS_ALU_NCH,
    localparam int CHW = mas_alu_idw(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [CHW-1:0] ptr,
    output logic [NCH-1:0] gnt,
    output logic [CHW-1:0] gnt_id,
    output logic           any_req
);

    int unsigned idx;

    // Scan from the farthest offset down so the nearest requester wins last
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        idx    = 0;
        for (int unsigned off = NCH; off > 0; off--) begin
            idx = 32'(ptr) + off - 1;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            if ((req & (NCH'(1) << idx)) != '0) begin
                gnt    = NCH'(1) << idx;
                gnt_id = CHW'(idx);
            end
        end
        any_req = |req;
    end

endmodule

// File: rtl/mas_alu_mc_top.sv
// Multi-channel MAS ALU: NCH requesters share one ALU with a shift-add multiplier
// through a round-robin arbiter; results are tagged with the served channel ID.
module mas_alu_mc_top
    import mas_alu_pkg::*;
#(
    parameter int  BLEN = MAS_ALU_BLEN,
    parameter int  NCH  = MAS_ALU_NCH,
    localparam int CHW  = mas_alu_idw(NCH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NCH-1:0]  mas_alu_req,
    input  type_mas_alu_cmd mas_alu_cmd [NCH],
    input  logic [BLEN-1:0] mas_alu_op1 [NCH],
    input  logic [BLEN-1:0] mas_alu_op2 [NCH],
    output logic [NCH-1:0]  mas_alu_ready,
    output logic [BLEN-1:0] mas_alu_res,
    output logic [CHW-1:0]  mas_alu_res_ch,
    output logic            mas_alu_err,
    output logic            mas_alu_busy
);

    localparam int SHW = $clog2(BLEN);

    type_mas_alu_state state, state_nxt;

    logic [NCH-1:0]  gnt;
    logic [CHW-1:0]  gnt_id;
    logic            any_req;
    logic [CHW-1:0]  ptr_q;
    logic [CHW-1:0]  ch_q;
    type_mas_alu_cmd cmd_q;
    logic [BLEN-1:0] op1_q, op2_q;
    logic [BLEN-1:0] mul_acc;
    logic [SHW-1:0]  mul_cnt;
    logic [BLEN-1:0] res_q;
    logic [CHW-1:0]  res_ch_q;
    logic            err_q;

    logic [3:0]      sel_cmd;
    logic [BLEN-1:0] sel_op1, sel_op2;
    logic [BLEN-1:0] alu_res, mul_step;
    logic            alu_err, mul_last;
    logic [SHW-1:0]  shamt;

    mas_alu_rr_arb #(.NCH(NCH)) u_arb (
        .req     (mas_alu_req),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .any_req (any_req)
    );

    always_comb begin
        sel_cmd = '0;
        sel_op1 = '0;
        sel_op2 = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (gnt[k]) begin
                sel_cmd = sel_cmd | mas_alu_cmd[k];
                sel_op1 = sel_op1 | mas_alu_op1[k];
                sel_op2 = sel_op2 | mas_alu_op2[k];
            end
        end
    end

    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        shamt   = op2_q[SHW-1:0];
        case (cmd_q)
            MAS_ALU_ADD: alu_res = op1_q + op2_q;
            MAS_ALU_SUB: alu_res = op1_q - op2_q;
            MAS_ALU_AND: alu_res = op1_q & op2_q;
            MAS_ALU_OR:  alu_res = op1_q | op2_q;
            MAS_ALU_XOR: alu_res = op1_q ^ op2_q;
            MAS_ALU_SLL: alu_res = op1_q << shamt;
            MAS_ALU_SRL: alu_res = op1_q >> shamt;
            MAS_ALU_SRA: alu_res = $unsigned($signed(op1_q) >>> shamt);
            MAS_ALU_MUL: alu_res = '0;
            default:     alu_err = 1'b1;
        endcase
    end

    // MUL reuses op1_q as the shifting multiplicand and op2_q as the shifting multiplier
    assign mul_step = mul_acc + (op2_q[0] ? op1_q : '0);
    assign mul_last = (mul_cnt == SHW'(BLEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (any_req) state_nxt = ST_EXEC;
            ST_EXEC: if (cmd_q != MAS_ALU_MUL || mul_last) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        mas_alu_ready  = (state == ST_DONE) ? (NCH'(1) << ch_q) : '0;
        mas_alu_busy   = (state != ST_IDLE);
        mas_alu_res    = res_q;
        mas_alu_res_ch = res_ch_q;
        mas_alu_err    = err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= '0;
            ch_q     <= '0;
            cmd_q    <= MAS_ALU_ADD;
            op1_q    <= '0;
            op2_q    <= '0;
            mul_acc  <= '0;
            mul_cnt  <= '0;
            res_q    <= '0;
            res_ch_q <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        ch_q    <= gnt_id;
                        cmd_q   <= type_mas_alu_cmd'(sel_cmd);
                        op1_q   <= sel_op1;
                        op2_q   <= sel_op2;
                        mul_acc <= '0;
                        mul_cnt <= '0;
                    end
                end
                ST_EXEC: begin
                    if (cmd_q == MAS_ALU_MUL) begin
                        mul_acc <= mul_step;
                        op1_q   <= op1_q << 1;
                        op2_q   <= op2_q >> 1;
                        mul_cnt <= mul_cnt + 1'b1;
                        if (mul_last) begin
                            res_q    <= mul_step;
                            err_q    <= 1'b0;
                            res_ch_q <= ch_q;
                        end
                    end else begin
                        res_q    <= alu_res;
                        err_q    <= alu_err;
                        res_ch_q <= ch_q;
                    end
                end
                ST_DONE: begin
                    ptr_q <= (ch_q == CHW'(NCH - 1)) ? '0 : ch_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mas_alu_mc_top.sv
// Self-checking bench for mas_alu_mc_top: directed corner cases plus randomized
// contention batches against a behavioural ALU/arbitration model.
module tb_mas_alu_mc_top;
    import mas_alu_pkg::*;

    localparam int BLEN = 32;
    localparam int NCH  = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NCH-1:0]  req;
    type_mas_alu_cmd cmd [NCH];
    logic [BLEN-1:0] op1 [NCH];
    logic [BLEN-1:0] op2 [NCH];
    logic [NCH-1:0]  ready;
    logic [BLEN-1:0] res;
    logic [1:0]      res_ch;
    logic            err, busy;

    logic            req_b;
    type_mas_alu_cmd cmd_b [1];
    logic [7:0]      op1_b [1];
    logic [7:0]      op2_b [1];
    logic            ready_b;
    logic [7:0]      res_b;
    logic            res_ch_b;
    logic            err_b, busy_b;

    mas_alu_mc_top #(.BLEN(BLEN), .NCH(NCH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mas_alu_req    (req),
        .mas_alu_cmd    (cmd),
        .mas_alu_op1    (op1),
        .mas_alu_op2    (op2),
        .mas_alu_ready  (ready),
        .mas_alu_res    (res),
        .mas_alu_res_ch (res_ch),
        .mas_alu_err    (err),
        .mas_alu_busy   (busy)
    );

    mas_alu_mc_top #(.BLEN(8), .NCH(1)) dut_b (
        .clk            (clk),
        .rst_n          (rst_n),
        .mas_alu_req    (req_b),
        .mas_alu_cmd    (cmd_b),
        .mas_alu_op1    (op1_b),
        .mas_alu_op2    (op2_b),
        .mas_alu_ready  (ready_b),
        .mas_alu_res    (res_b),
        .mas_alu_res_ch (res_ch_b),
        .mas_alu_err    (err_b),
        .mas_alu_busy   (busy_b)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int ref_ptr = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // {err, res} straight from the command definitions
    function automatic logic [32:0] ref_alu(input type_mas_alu_cmd c, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] p;
        int          sh;
        sh = int'(b % 32);
        case (c)
            MAS_ALU_ADD: return {1'b0, a + b};
            MAS_ALU_SUB: return {1'b0, a - b};
            MAS_ALU_AND: return {1'b0, a & b};
            MAS_ALU_OR:  return {1'b0, a | b};
            MAS_ALU_XOR: return {1'b0, a ^ b};
            MAS_ALU_SLL: return {1'b0, a << sh};
            MAS_ALU_SRL: return {1'b0, a >> sh};
            MAS_ALU_SRA: return {1'b0, (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0)};
            MAS_ALU_MUL: begin
                p = 64'(a) * 64'(b);
                return {1'b0, p[31:0]};
            end
            default:     return {1'b1, 32'h0};
        endcase
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    function automatic type_mas_alu_cmd rnd_cmd();
        int r;
        r = $urandom_range(0, 11);
        if (r <= 8) return type_mas_alu_cmd'(4'(r));
        return type_mas_alu_cmd'(4'($urandom_range(9, 15)));
    endfunction

    // Call at the start of an IDLE cycle; channels in mask request with preset cmd/ops
    // and each drops its request once served.
    task automatic run_batch(input logic [NCH-1:0] mask);
        logic [NCH-1:0] pending;
        logic [32:0]    exp;
        int             exp_ch, n, lat;
        pending = mask;
        req     = mask;
        while (pending != '0) begin
            exp_ch = -1;
            for (int k = 0; k < NCH; k++) begin
                int c = (ref_ptr + k) % NCH;
                if (exp_ch < 0 && pending[c]) exp_ch = c;
            end
            lat = (cmd[exp_ch] == MAS_ALU_MUL) ? BLEN + 1 : 2;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (ready == '0 && n < lat + 6);
            check("ready_seen", 64'(ready != '0), 64'(1));
            if (ready == '0) begin
                req = '0;
                repeat (BLEN + 4) @(posedge clk);
                #1;
                return;
            end
            exp = ref_alu(cmd[exp_ch], op1[exp_ch], op2[exp_ch]);
            check("latency", 64'(n), 64'(lat + 1));
            check("ready",   64'(ready), 64'(1) << exp_ch);
            check("res_ch",  64'(res_ch), 64'(exp_ch));
            check("res",     64'(res), 64'(exp[31:0]));
            check("err",     64'(err), 64'(exp[32]));
            check("busy",    64'(busy), 64'(1));
            req[exp_ch]     = 1'b0;
            pending[exp_ch] = 1'b0;
            ref_ptr         = (exp_ch + 1) % NCH;
        end
        @(negedge clk);
        check("idle_ready", 64'(ready), 64'(0));
        check("idle_busy",  64'(busy), 64'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, pulses;
        logic [NCH-1:0] m;
        logic [7:0] a8, b8;

        rst_n = 1'b0;
        req   = '0;
        req_b = 1'b0;
        cmd_b[0] = MAS_ALU_ADD;
        op1_b[0] = '0;
        op2_b[0] = '0;
        for (int k = 0; k < NCH; k++) begin
            cmd[k] = MAS_ALU_ADD;
            op1[k] = '0;
            op2[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(ready), 64'(0));
        check("rst_res",   64'(res), 64'(0));
        check("rst_res_ch", 64'(res_ch), 64'(0));
        check("rst_err",   64'(err), 64'(0));
        check("rst_busy",  64'(busy), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ADD wrap on ch2
        cmd[2] = MAS_ALU_ADD; op1[2] = 32'hFFFF_FFFF; op2[2] = 32'h1;
        run_batch(4'b0100);
        // SRL / SRA with shift amount masked to 1
        cmd[3] = MAS_ALU_SRL; op1[3] = 32'h8000_0000; op2[3] = 32'h21;
        run_batch(4'b1000);
        check("srl_value", 64'(res), 64'(32'h4000_0000));
        cmd[1] = MAS_ALU_SRA; op1[1] = 32'h8000_0000; op2[1] = 32'h21;
        run_batch(4'b0010);
        check("sra_value", 64'(res), 64'(32'hC000_0000));

        // Abort a MUL on ch0 in its third EXEC cycle
        cmd[0] = MAS_ALU_MUL; op1[0] = 32'h1234_5678; op2[0] = 32'h9ABC_DEF1;
        req = 4'b0001;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        req   = '0;
        #1;
        check("abort_ready",  64'(ready), 64'(0));
        check("abort_busy",   64'(busy), 64'(0));
        check("abort_res",    64'(res), 64'(0));
        check("abort_res_ch", 64'(res_ch), 64'(0));
        check("abort_err",    64'(err), 64'(0));
        ref_ptr = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (BLEN + 4) begin
            @(negedge clk);
            if (ready != '0) pulses++;
        end
        check("abort_no_ready", 64'(pulses), 64'(0));
        @(posedge clk);
        #1;
        for (int k = 0; k < NCH; k++) begin
            cmd[k] = MAS_ALU_ADD; op1[k] = rnd_op(); op2[k] = rnd_op();
        end
        run_batch(4'b1111);

        // Illegal command then a legal one on ch1
        cmd[1] = type_mas_alu_cmd'(4'hF); op1[1] = 32'hDEAD_BEEF; op2[1] = 32'h5;
        run_batch(4'b0010);
        cmd[1] = MAS_ALU_ADD; op1[1] = 32'h7; op2[1] = 32'h9;
        run_batch(4'b0010);

        // Fairness: all channels request continuously
        for (int k = 0; k < NCH; k++) begin
            cmd[k] = MAS_ALU_SUB; op1[k] = 32'd10; op2[k] = 32'(k);
        end
        req = '1;
        for (int i = 0; i < 2 * NCH; i++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (ready == '0 && n < 10);
            check("fair_gap",    64'(n), 64'(3));
            check("fair_res_ch", 64'(res_ch), 64'(ref_ptr));
            check("fair_res",    64'(res), 64'(32'(10 - ref_ptr)));
            ref_ptr = (ref_ptr + 1) % NCH;
        end
        req = '0;
        @(posedge clk);
        #1;

        // Randomized contention batches
        for (int b = 0; b < 25; b++) begin
            for (int k = 0; k < NCH; k++) begin
                cmd[k] = rnd_cmd(); op1[k] = rnd_op(); op2[k] = rnd_op();
            end
            m = 4'($urandom_range(1, 15));
            run_batch(m);
        end

        // Single-channel, 8-bit instance: MUL timing and results
        for (int t = 0; t < 3; t++) begin
            a8 = (t == 0) ? 8'h0F : 8'($urandom);
            b8 = (t == 0) ? 8'h11 : 8'($urandom);
            cmd_b[0] = MAS_ALU_MUL; op1_b[0] = a8; op2_b[0] = b8;
            req_b = 1'b1;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!ready_b && n < 16);
            check("b_latency", 64'(n), 64'(10));
            check("b_res",     64'(res_b), 64'(8'(16'(a8) * 16'(b8))));
            check("b_res_ch",  64'(res_ch_b), 64'(0));
            check("b_err",     64'(err_b), 64'(0));
            req_b = 1'b0;
            @(negedge clk);
            check("b_idle_ready", 64'(ready_b), 64'(0));
            check("b_idle_busy",  64'(busy_b), 64'(0));
            @(posedge clk);
            #1;
        end
        check("b_mul_0f_11", 64'(ref_alu(MAS_ALU_MUL, 32'h0F, 32'h11)), 64'(33'hFF));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
